// File: rtl/uart_sample_packer.sv
// Packs UART receiver bytes (low then high) into 16-bit samples and queues them in a FWFT FIFO.
// Optional partial-sample timeout is enabled by defining UART_SAMPLE_PACKER_TIMEOUT_EN.
module uart_sample_packer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rxbyte,
    input  logic                     rxdone,
    output logic [15:0]              sample,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_sample_packer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t         r_state;
    logic           r_rxdone_q;
    logic [7:0]     r_low_q;

    logic [15:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_sample;
    logic           r_sample_valid;
    logic           r_overflow;

    logic           w_accept;
    logic           w_push;
    logic [15:0]    w_push_data;
    logic           w_pop;
    logic           w_push_ok;
    logic [AW-1:0]  w_next_rd;
    logic [CW-1:0]  w_next_count;
    logic           w_bypass;

    assign w_accept     = rxdone & ~r_rxdone_q;
    assign w_push       = w_accept & (r_state == ST_HIGH);
    assign w_push_data  = {rxbyte, r_low_q};
    assign w_pop        = (r_count != '0) & sample_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign w_push_ok    = w_push & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_next_rd    = r_rd_ptr + AW'(w_pop);
    assign w_next_count = r_count + CW'(w_push_ok) - CW'(w_pop);
    // New head is the word being written when the FIFO is otherwise empty after this cycle
    assign w_bypass     = w_push_ok & ((r_count - CW'(w_pop)) == '0);

`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]  r_tcnt;
    logic           r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // Byte pairing FSM with receiver done-level edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_LOW;
            r_rxdone_q <= 1'b0;
            r_low_q    <= 8'h00;
`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_rxdone_q <= rxdone;
            case (r_state)
                ST_LOW: begin
                    if (w_accept) begin
                        r_low_q <= rxbyte;
                        r_state <= ST_HIGH;
`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                ST_HIGH: begin
                    if (w_accept) begin
                        r_state <= ST_LOW;
`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_state       <= ST_LOW;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
`endif
                    end
                end
                default: r_state <= ST_LOW;
            endcase
        end
    end

    // Sample storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // FIFO bookkeeping and registered head/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_sample       <= 16'h0000;
            r_sample_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr       <= w_next_rd;
            r_count        <= w_next_count;
            r_sample_valid <= (w_next_count != '0);
            if (w_next_count == '0) begin
                r_sample <= 16'h0000;
            end else if (w_bypass) begin
                r_sample <= w_push_data;
            end else begin
                r_sample <= r_mem[w_next_rd];
            end
            if (w_push & ~w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign count        = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_sample_packer.sv
// Self-checking bench for uart_sample_packer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized traffic phase.
module tb_uart_sample_packer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rxbyte = 8'h00;
    logic          rxdone = 1'b0;
    logic          sample_ready = 1'b0;
    logic [15:0]   sample;
    logic          sample_valid;
    logic [CW-1:0] count;
    logic          overflow;
    logic          timeout_err;

    uart_sample_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxbyte       (rxbyte),
        .rxdone       (rxdone),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .count        (count),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending low byte with its age, plus a queue of stored samples
    bit          m_prev     = 1'b0;
    bit          m_have_low = 1'b0;
    logic [7:0]  m_low      = 8'h00;
    int          m_cyc      = 0;
    int          m_low_cyc  = 0;
    logic [15:0] m_q[$];
    bit          m_ovf      = 1'b0;
    bit          m_tmo      = 1'b0;

    task automatic model_step();
        bit          acc;
        bit          push;
        logic [15:0] data;
        m_cyc++;
        acc    = rxdone && !m_prev;
        m_prev = rxdone;
        push   = 1'b0;
        data   = 16'h0000;
        if (m_have_low) begin
            if (acc) begin
                push       = 1'b1;
                data       = {rxbyte, m_low};
                m_have_low = 1'b0;
            end else if (TO_EN && (m_cyc - m_low_cyc) >= int'(TIMEOUT)) begin
                m_have_low = 1'b0;
                m_tmo      = 1'b1;
            end
        end else if (acc) begin
            m_have_low = 1'b1;
            m_low      = rxbyte;
            m_low_cyc  = m_cyc;
        end
        if (m_q.size() != 0 && sample_ready) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(data);
            else m_ovf = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_prev = 1'b0; m_have_low = 1'b0; m_low = 8'h00;
            m_q.delete(); m_ovf = 1'b0; m_tmo = 1'b0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model_sample", 32'(sample), 32'((m_q.size() != 0) ? m_q[0] : 16'h0000));
            chk("model_valid",  32'(sample_valid), 32'(m_q.size() != 0));
            chk("model_count",  32'(count), 32'(m_q.size()));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            chk("model_timeout",  32'(timeout_err), 32'(m_tmo));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) sample_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one byte; rxdone high for 'hold' edges, returns just after the accept edge when hold=1
    task automatic send_byte(input logic [7:0] b, input int hold);
        tick();
        rxbyte = b;
        rxdone = 1'b1;
        repeat (hold) tick();
        rxdone = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s);
        send_byte(s[7:0], 1);
        send_byte(s[15:8], 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rxdone = 1'b0;
        sample_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        sample_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        sample_ready = 1'b0;
    endtask

    initial begin
        int g;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_sample", 32'(sample), 32'h0);
        chk("reset_valid", 32'(sample_valid), 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        chk("reset_timeout", 32'(timeout_err), 32'h0);
        chk_en = 1'b1;

        // Pairing: low then high
        send_byte(8'h34, 1);
        send_byte(8'h12, 1);
        chk("pair_sample", 32'(sample), 32'h1234);
        chk("pair_valid", 32'(sample_valid), 32'h1);
        chk("pair_count", 32'(count), 32'h1);
        drain();
        chk("pair_drained", 32'(count), 32'h0);

        // Edge detect: a long rxdone level is one byte
        send_byte(8'h55, 5);
        send_byte(8'h66, 1);
        chk("edge_sample", 32'(sample), 32'h6655);
        chk("edge_count", 32'(count), 32'h1);
        drain();

        // Full / overflow: 17 pushes, the last is dropped
        for (int i = 0; i <= 16; i++) send_sample(16'(i));
        chk("full_count", 32'(count), 32'd16);
        chk("full_overflow", 32'(overflow), 32'h1);
        for (int k = 0; k < 16; k++) begin
            chk("drain_order", 32'(sample), 32'(k));
            sample_ready = 1'b1;
            @(negedge clk);
        end
        sample_ready = 1'b0;
        chk("drain_empty_count", 32'(count), 32'h0);
        chk("drain_empty_sample", 32'(sample), 32'h0);

        // Full with a pop in the same cycle as the completing push
        do_reset();
        for (int i = 0; i < 16; i++) send_sample(16'h0100 + 16'(i));
        send_byte(8'hEE, 1);
        @(negedge clk);
        rxbyte = 8'hDD;
        rxdone = 1'b1;
        sample_ready = 1'b1;
        @(negedge clk);
        rxdone = 1'b0;
        sample_ready = 1'b0;
        chk("fullpop_count", 32'(count), 32'd16);
        chk("fullpop_overflow", 32'(overflow), 32'h0);
        chk("fullpop_head", 32'(sample), 32'h0101);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("fullpop_last", 32'(sample), 32'hDDEE);
            sample_ready = 1'b1;
            @(negedge clk);
        end
        sample_ready = 1'b0;

        // Partial sample left idle past the timeout
        do_reset();
        send_byte(8'hAA, 1);
        repeat (101) tick();
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
`ifdef UART_SAMPLE_PACKER_TIMEOUT_EN
        chk("timeout_flag", 32'(timeout_err), 32'h1);
        chk("timeout_sample", 32'(sample), 32'h2211);
`else
        chk("notimeout_flag", 32'(timeout_err), 32'h0);
        chk("notimeout_sample", 32'(sample), 32'h11AA);
`endif
        chk("timeout_count", 32'(count), 32'h1);

        // Gaps straddling the timeout boundary
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(i + 8'h40), 1);
            repeat (TIMEOUT - 4 + i) tick();
            send_byte(8'(i + 8'h80), 1);
            repeat (3) tick();
        end
        drain();

        // Asynchronous reset mid-operation, rxdone already high at release
        do_reset();
        for (int i = 0; i < 3; i++) send_sample(16'hA000 + 16'(i));
        send_byte(8'h77, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_valid", 32'(sample_valid), 32'h0);
        chk("arst_sample", 32'(sample), 32'h0);
        chk("arst_flags", 32'({overflow, timeout_err}), 32'h0);
        rxbyte = 8'h01;
        rxdone = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rxdone = 1'b0;
        send_byte(8'h02, 1);
        chk("arst_next_sample", 32'(sample), 32'h0201);
        chk("arst_next_count", 32'(count), 32'h1);

        // Randomized traffic with random consumer back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TIMEOUT - 3, TIMEOUT + 1))
                                             : int'($urandom_range(0, 3));
            repeat (g) tick();
            send_byte(8'($urandom), int'($urandom_range(1, 3)));
        end
        rand_ready = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_sample_packer.md
# uart_sample_packer

Downstream consumer of the 8N1 UART receiver: turns the receiver's byte stream into 16-bit little-endian samples and buffers them in a small FIFO for the FFT input stage. It detects each new received byte on the receiver's `rxdone` level and pairs bytes as low then high. Completed samples go out over a valid/ready handshake. A partial sample is discarded if the second byte does not arrive in time.

## Interface
- `DEPTH`, 16: FIFO depth in samples; power of two, ≥2.
- `TIMEOUT`, 20000: max `clk` cycles between low and high byte before the partial is discarded.
- `clk`  in  1  single clock; all inputs synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `rxbyte`  in  8  byte from receiver; stable while `rxdone`=1.
- `rxdone`  in  1  receiver done level; a 0→1 transition marks one new byte.
- `sample`  out  16  FIFO head `{high,low}`; 16'h0000 when empty.
- `sample_valid`  out  1  FIFO non-empty.
- `sample_ready`  in  1  consumer accepts head when `sample_valid`=1.
- `count`  out  $clog2(DEPTH)+1  samples held, 0..DEPTH.
- `overflow`  out  1  sticky: a completed sample was dropped, FIFO full.
- `timeout_err`  out  1  sticky: a partial sample was discarded on timeout.

## Operation
- Edge detect: register `rxdone_q`. A byte is accepted in a cycle where `rxdone`=1 and `rxdone_q`=0. Holding `rxdone` high for many cycles yields exactly one byte.
- FSM states:
  - LOW: on accept, latch `rxbyte` into `low_q`, clear the timeout counter, go to HIGH.
  - HIGH: on accept, form `{rxbyte, low_q}`, request a push, go to LOW.
  - HIGH, no accept: increment the timeout counter.
- Timeout (HIGH): when the counter reaches `TIMEOUT`, go to LOW, set `timeout_err`, discard `low_q`. If an accept and the timeout occur in the same cycle, the accept wins and the sample completes.
- FIFO: circular buffer, `DEPTH` entries, first-word-fall-through.
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - `count` is tracked separately.
- Pop: occurs when `sample_valid` && `sample_ready`.
- Push: succeeds if `count`<`DEPTH`, or if a pop happens in the same cycle. Otherwise the sample is dropped and `overflow` is set.
- Simultaneous push and pop: `count` unchanged, both pointers advance. This holds when full (the push is accepted) and when non-empty.
- Pop while empty: ignored.
- Sticky flags clear only on `rst`.
- Reset behaviour:
  - Asynchronous, effective immediately, including mid-sample or mid-handshake.
  - On reset: state LOW, pointers 0, `count`=0, `rxdone_q`=0, `low_q`=0, timeout counter 0.
  - Memory contents are not reset.
- If `rxdone` is already 1 when `rst` deasserts, one byte is accepted on the first clock, because `rxdone_q` resets to 0.

## Timing
- Reset values: `sample`=16'h0000, `sample_valid`=0, `count`=0, `overflow`=0, `timeout_err`=0.
- Byte accept at rising edge N (`rxdone` sampled 1, `rxdone_q` 0):
  - LOW: `low_q` is valid after edge N.
  - HIGH: the sample is written at edge N; `sample_valid`/`count` update after edge N.
  - Latency is one cycle from sampled `rxdone` to visible output.
- A pop at edge N exposes the next head (or 16'h0000) after edge N.
- Minimum spacing between accepted bytes: 2 cycles, since `rxdone` must return low.
- `overflow` and `timeout_err` assert in the cycle after the causing edge.

## Configuration
- `UART_SAMPLE_PACKER_TIMEOUT_EN` defined: timeout counter and FSM timeout transition are present, and `timeout_err` behaves as above.
- Not defined: no counter; the FSM waits in HIGH indefinitely; `timeout_err` is tied to 0; `TIMEOUT` is ignored.

## Test plan
- Pairing: bytes 0x34 then 0x12, `sample_ready`=0 → `sample`=16'h1234, `sample_valid`=1, `count`=1 one cycle after the second accept.
- Edge detect: `rxdone` held high 5 cycles with 0x55, low, then high with 0x66 → exactly one sample 16'h6655.
- Full/overflow: `sample_ready`=0, push 17 samples 16'h0000..16'h0010 → `count`=16, `overflow`=1, then drain yields 0x0000..0x000F in order and `count` wraps back to 0.
- Full with simultaneous pop: FIFO full, `sample_ready`=1 in the cycle a push completes → `count` stays 16, `overflow` stays 0, new sample is last in drain order.
- Timeout (macro on, `TIMEOUT`=100): byte 0xAA, idle 101 cycles, then 0x11, 0x22 → `timeout_err`=1, only sample 16'h2211. With the macro off → sample 16'h11AA, `timeout_err`=0.
- Reset mid-operation: after low byte 0x77 plus 3 queued samples, pulse `rst` → `count`=0, `sample_valid`=0, flags 0. Next bytes 0x01, 0x02 → 16'h0201.
